// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package adder_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladd.sv
// Single-bit combinational full adder.
module fulladd (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);

  // Sum and majority carry of three input bits
  always_comb begin
    sum   = x ^ y ^ z;
    carry = (x & y) | (x & z) | (y & z);
  end

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: one bit per clock, LSB first; result published after WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_4bit
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_n;
  logic             load;
  logic             step;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  fulladd u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .z     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and datapath control
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and published result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      valid <= 1'b0;
      ready <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      ready <= (state_n != RUN);
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
        valid <= 1'b0;
      end else if (step) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        r_sh  <= {fa_sum, r_sh[WIDTH-1:1]};
        carry <= fa_carry;
        cnt   <= cnt + CW'(1);
        if (last_bit) begin
          s     <= {fa_sum, r_sh[WIDTH-1:1]};
          cout  <= fa_carry;
          valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          // carry currently held is the carry into the MSB
          ovf   <= carry ^ fa_carry;
`endif
        end
      end
    end
  end

endmodule

// File: doc/serial_adder_4bit.md
SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits; the only verified value is 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH, first operand.
REQ-006 SHALL have port b, input, WIDTH, second operand.
REQ-007 SHALL have port cin, input, 1, carry-in to bit 0.
REQ-008 SHALL have port ready, output, 1, high when a start will be accepted.
REQ-009 SHALL have port valid, output, 1, high when s/cout hold a completed result.
REQ-010 SHALL have port s, output, WIDTH, sum a+b+cin mod 2^WIDTH.
REQ-011 SHALL have port cout, output, 1, carry out of the MSB.
REQ-012 SHALL have port ovf, output, 1, signed overflow, present only when SERIAL_ADD_OVF_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert ready in IDLE and DONE, and deassert it in RUN.
REQ-015 SHALL, on a start sampled high at edge N with ready=1, latch a, b and cin into internal shift registers and carry flop, clear the bit counter, enter RUN and drop valid.
REQ-016 SHALL in RUN compute one bit per edge, LSB first, via one full adder on (a_sh[0], b_sh[0], carry), shift the sum bit into the result shift register MSB-first-in, and update carry.
REQ-017 SHALL compute bits at edges N+1..N+WIDTH; at edge N+WIDTH it SHALL load s and cout (and ovf) from the completed result, set valid=1 and enter DONE (latency WIDTH cycles, start-to-valid).
REQ-018 SHALL hold s, cout and ovf at their previous values throughout RUN; partial sums are never visible.
REQ-019 SHALL keep valid high in DONE until the next accepted start or reset.
REQ-020 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-021 SHALL accept start in DONE exactly as in IDLE, allowing back-to-back operations with one idle-free cycle.
REQ-022 SHALL ignore changes on a, b and cin after the start edge.
REQ-023 SHALL wrap the sum modulo 2^WIDTH, with the carry beyond the MSB reported only on cout.

Reset
REQ-024 SHALL, while rst_n is low at a clock edge, force state IDLE, and set s=0, cout=0, ovf=0, valid=0, ready=1, counter=0 and carry=0.
REQ-025 SHALL abort any in-progress RUN on reset with no result published; the first start after rst_n rises SHALL be handled normally.

Configuration
REQ-026 SHALL, with SERIAL_ADD_OVF_EN defined, provide port ovf registered with s and equal to the carry into the MSB XOR the carry out of the MSB.
REQ-027 SHALL, without SERIAL_ADD_OVF_EN, omit port ovf and its logic; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL take the FSM state enum (IDLE/RUN/DONE) and the WIDTH default constant from shared package adder_pkg.
REQ-029 SHALL instantiate one combinational sub-module, fulladd (inputs x, y, z; outputs sum, carry), for the per-bit add.

Verification
REQ-030 SHALL cover: a=3, b=5, cin=0, start -> 4 cycles later valid=1, s=8, cout=0, ovf=1.
REQ-031 SHALL cover: a=15, b=1, cin=0 -> s=0, cout=1, ovf=0; and a=7, b=8, cin=1 -> s=0, cout=1, ovf=0.
REQ-032 SHALL cover: start pulsed with a=1, b=1 on cycle 2 of RUN of 2+2 -> result s=4, cout=0; no second result; ready=0 during RUN.
REQ-033 SHALL cover: rst_n low for 1 cycle mid-RUN -> next cycle valid=0, s=0, ready=1; a new start of 6+6 -> s=12, cout=0.
REQ-034 SHALL cover: back-to-back start in DONE (9+9, then 1+2) -> valid drops for 4 cycles, then s=3, cout=0; the first result s=2, cout=1 is observed before it.
REQ-035 SHALL run the bench with and without SERIAL_ADD_OVF_EN, with identical s/cout/valid traces in both builds.
